// File: rtl/fill_event_tracker.sv
// fill_event_tracker
// Watches the fill controller's saturation flag, timestamps each rising edge
// with the cycle distance to the previous one, and queues {index, period}
// records in a small FIFO drained through a valid/ready handshake.
//
// Optional feature: define FILL_WDOG_EN to build the missing-fill watchdog;
// otherwise wdog is tied low and no compare logic exists.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   sig        in   saturation level (registered upstream)
//   rd_ready   in   consumer ready
//   rd_valid   out  FIFO head holds a record
//   rd_index   out  event index of the head record
//   rd_period  out  period field of the head record
//   overflow   out  sticky: a record was dropped since reset
//   wdog       out  per >= WDOG_LIMIT (FILL_WDOG_EN only, else 0)
module fill_event_tracker #(
  parameter int unsigned PBITS      = 20,
  parameter int unsigned ECBITS     = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WDOG_LIMIT = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [ECBITS-1:0] rd_index,
  output logic [PBITS-1:0]  rd_period,
  output logic              overflow,
  output logic              wdog
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [ECBITS-1:0] index;
    logic [PBITS-1:0]  period;
  } rec_t;

  // Elaboration-time parameter sanity
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fill_event_tracker: DEPTH must be a power of 2 and >= 2");
  end
  if ((64'(WDOG_LIMIT) >> PBITS) != 64'd0) begin : g_bad_limit
    $error("fill_event_tracker: WDOG_LIMIT must fit in PBITS bits");
  end

  logic              sig_q;
  logic              seen;
  logic [PBITS-1:0]  per;
  logic [ECBITS-1:0] ec;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  rec_t              mem [DEPTH];

  logic rise_c;
  logic empty_c;
  logic full_c;
  logic pop_c;
  logic push_c;
  rec_t rec_c;
  rec_t head_c;

  // Edge detect and FIFO control
  always_comb begin
    rise_c  = sig & ~sig_q;
    empty_c = (wr_ptr == rd_ptr);
    full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop_c   = ~empty_c & rd_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle
    push_c  = rise_c & (~full_c | pop_c);
    rec_c.index  = ec;
    // First edge after reset has no predecessor, so its period is 0
    rec_c.period = seen ? per : '0;
  end

  // Edge history and period counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
      seen  <= 1'b0;
      per   <= '0;
      ec    <= '0;
    end else begin
      sig_q <= sig;
      if (rise_c) begin
        seen <= 1'b1;
        per  <= PBITS'(1);
        // Dropped edges advance the index too, so gaps reveal losses
        ec   <= ec + ECBITS'(1);
      end else if (per != '1) begin
        per <= per + PBITS'(1);
      end
    end
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      if (rise_c && !push_c) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= rec_c;
  end

  // Head of FIFO
  always_comb begin
    head_c    = mem[rd_ptr[AW-1:0]];
    rd_valid  = ~empty_c;
    rd_index  = head_c.index;
    rd_period = head_c.period;
  end

`ifdef FILL_WDOG_EN
  // Alarm while too long has passed since reset or the last edge
  assign wdog = (per >= PBITS'(WDOG_LIMIT));
`else
  assign wdog = 1'b0;
`endif

endmodule

// File: tb/tb_fill_event_tracker.sv
// Bench for fill_event_tracker: directed scenarios plus a random phase, all
// checked every cycle against a timestamp/queue reference model.
module tb_fill_event_tracker;

  localparam int unsigned PBITS  = 8;
  localparam int unsigned ECBITS = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LIMIT  = 20;
  localparam int          PMAX   = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              sig;
  logic              rd_ready;
  logic              rd_valid;
  logic [ECBITS-1:0] rd_index;
  logic [PBITS-1:0]  rd_period;
  logic              overflow;
  logic              wdog;

  fill_event_tracker #(
    .PBITS(PBITS), .ECBITS(ECBITS), .DEPTH(DEPTH), .WDOG_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .sig(sig), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_index(rd_index), .rd_period(rd_period),
    .overflow(overflow), .wdog(wdog)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int nchk  = 0;

  // Reference model: absolute cycle stamps and a record queue
  int  cyc      = 0;
  int  base     = 0;   // cycle at which the period counter read 0
  bit  seen     = 0;
  bit  prev_sig = 0;
  int  m_ec     = 0;
  bit  m_ovf    = 0;
  bit  checking = 0;
  int  m_idx[$];
  int  m_per[$];

  // Records the DUT actually handed over, and last observed outputs
  logic [31:0] got_idx[$];
  logic [31:0] got_per[$];
  logic        o_valid;
  logic        o_ovf;
  logic        o_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input logic s, input logic r, input logic rs);
    int  perv;
    bit  rise;
    bit  pop;
    bit  exp_wd;
    sig      = s;
    rd_ready = r;
    rst      = rs;
    @(negedge clk);
    o_valid = rd_valid;
    o_ovf   = overflow;
    o_wd    = wdog;
    if (rd_valid === 1'b1 && r) begin
      got_idx.push_back(32'(rd_index));
      got_per.push_back(32'(rd_period));
    end
    perv = (cyc - base > PMAX) ? PMAX : cyc - base;
`ifdef FILL_WDOG_EN
    exp_wd = (perv >= int'(LIMIT));
`else
    exp_wd = 1'b0;
`endif
    if (checking) begin
      chk("valid", 32'(rd_valid), 32'(m_idx.size() != 0));
      if (m_idx.size() != 0) begin
        chk("index", 32'(rd_index), m_idx[0]);
        chk("period", 32'(rd_period), m_per[0]);
      end
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("wdog", 32'(wdog), 32'(exp_wd));
    end
    if (rs) begin
      m_idx.delete();
      m_per.delete();
      m_ovf    = 0;
      m_ec     = 0;
      seen     = 0;
      prev_sig = 0;
      base     = cyc + 1;
      checking = 1;
    end else begin
      rise = s && !prev_sig;
      pop  = (m_idx.size() != 0) && r;
      if (pop) begin
        void'(m_idx.pop_front());
        void'(m_per.pop_front());
      end
      if (rise) begin
        if (m_idx.size() < int'(DEPTH)) begin
          m_idx.push_back(m_ec);
          m_per.push_back(seen ? perv : 0);
        end else begin
          m_ovf = 1;
        end
        m_ec = (m_ec + 1) % 256;
        seen = 1;
        base = cyc;
      end
      prev_sig = s;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_idx.delete();
    got_per.delete();
  endtask

  logic vh[32];
  logic wh[32];
  logic any_wd;
  logic s_r;
  logic r_r;

  initial begin
    sig = 0; rd_ready = 0; rst = 1;

    // Scenario 1: level 5..9 then pulse at 17, consumer always ready
    step(0, 0, 1);
    clear_got();
    for (int c = 0; c < 25; c++) begin
      step(logic'((c >= 5 && c <= 9) || c == 17), 1'b1, 1'b0);
      vh[c] = o_valid;
    end
    chk("s1_valid_c5", 32'(vh[5]), 0);
    chk("s1_valid_c6", 32'(vh[6]), 1);
    chk("s1_count", got_idx.size(), 2);
    if (got_idx.size() >= 2) begin
      chk("s1_rec0_idx", got_idx[0], 0);
      chk("s1_rec0_per", got_per[0], 0);
      chk("s1_rec1_idx", got_idx[1], 1);
      chk("s1_rec1_per", got_per[1], 12);
    end

    // Scenario 2: five edges with no consumer, then drain and one more edge
    step(0, 0, 1);
    clear_got();
    for (int c = 0; c < 15; c++) step(logic'(c % 3 == 1), 1'b0, 1'b0);
    chk("s2_overflow", 32'(o_ovf), 1);
    for (int c = 0; c < 6; c++) step(0, 1, 0);
    chk("s2_drain_count", got_idx.size(), 4);
    for (int i = 0; i < got_idx.size() && i < 4; i++) chk("s2_drain_idx", got_idx[i], i);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("s2_after_count", got_idx.size(), 5);
    if (got_idx.size() >= 5) chk("s2_after_idx", got_idx[4], 5);

    // Scenario 3: full FIFO, edge coincides with a pop
    step(0, 0, 1);
    clear_got();
    for (int c = 0; c < 12; c++) step(logic'(c % 3 == 1), 1'b0, 1'b0);
    step(0, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    chk("s3_no_overflow", 32'(o_ovf), 0);
    for (int c = 0; c < 6; c++) step(0, 1, 0);
    chk("s3_count", got_idx.size(), 5);
    for (int i = 1; i < got_idx.size() && i < 5; i++) chk("s3_idx", got_idx[i], i);

    // Scenario 4: edges 301 cycles apart saturate the period
    step(0, 0, 1);
    clear_got();
    step(1, 0, 0);
    for (int c = 0; c < 300; c++) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("s4_count", got_idx.size(), 2);
    if (got_idx.size() >= 2) begin
      chk("s4_first_per", got_per[0], 0);
      chk("s4_sat_per", got_per[1], 255);
    end

    // Scenario 5: watchdog around a 26-cycle gap
    step(0, 0, 1);
    step(1, 1, 0);
    any_wd = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      step(logic'(k == 26), 1'b1, 1'b0);
      wh[k] = o_wd;
      any_wd = any_wd | o_wd;
    end
    chk("s5_wdog_k19", 32'(wh[19]), 0);
`ifdef FILL_WDOG_EN
    chk("s5_wdog_k20", 32'(wh[20]), 1);
    chk("s5_wdog_k26", 32'(wh[26]), 1);
    chk("s5_wdog_k27", 32'(wh[27]), 0);
`else
    chk("s5_wdog_never", 32'(any_wd), 0);
`endif

    // Scenario 6: reset with three entries queued and overflow set
    step(0, 0, 1);
    for (int c = 0; c < 15; c++) step(logic'(c % 3 == 1), 1'b0, 1'b0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("s6_pre_overflow", 32'(o_ovf), 1);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("s6_valid_cleared", 32'(o_valid), 0);
    chk("s6_overflow_cleared", 32'(o_ovf), 0);
    clear_got();
    step(1, 1, 0);
    step(0, 1, 0);
    chk("s6_count", got_idx.size(), 1);
    if (got_idx.size() >= 1) begin
      chk("s6_idx", got_idx[0], 0);
      chk("s6_per", got_per[0], 0);
    end

    // Random phase: bursty sig, random consumer, rare resets
    s_r = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) s_r = ~s_r;
      r_r = (c % 200 < 100) ? logic'($urandom_range(0, 3) == 0) : logic'($urandom_range(0, 1));
      step(s_r, r_r, logic'($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
